// File: rtl/unified_mem_arbiter_pkg.sv
// unified_mem_arbiter_pkg: shared types and limits for the unified memory arbiter.
// Provides the FSM state type, the requester port id type and the maximum
// supported memory latency.
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_e;
    typedef enum logic {PORT_IF = 1'b0, PORT_DATA = 1'b1} port_e;
    localparam int MAX_MEM_LAT = 4;
endpackage

// File: rtl/unified_mem_arbiter_if.sv
// unified_mem_arbiter_if: request/response/memory bus bundle of the arbiter.
// Ports: IF request/response (if_*), DATA request/response (d_*),
// single-port memory side (mem_*).
// Modports: slave = arbiter side, master = core/memory environment side.
interface unified_mem_arbiter_if #(parameter int AW = 32);
    logic          if_req_valid;
    logic          if_req_ready;
    logic [AW-1:0] if_req_addr;
    logic          if_rsp_valid;
    logic [31:0]   if_rsp_rdata;
    logic          if_rsp_err;
    logic          d_req_valid;
    logic          d_req_ready;
    logic [AW-1:0] d_req_addr;
    logic          d_req_we;
    logic [31:0]   d_req_wdata;
    logic [3:0]    d_req_wstrb;
    logic          d_rsp_valid;
    logic [31:0]   d_rsp_rdata;
    logic          d_rsp_err;
    logic          mem_en;
    logic          mem_we;
    logic [AW-3:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_wstrb;
    logic [31:0]   mem_rdata;
    modport slave (
        input  if_req_valid, if_req_addr, d_req_valid, d_req_addr, d_req_we,
               d_req_wdata, d_req_wstrb, mem_rdata,
        output if_req_ready, if_rsp_valid, if_rsp_rdata, if_rsp_err,
               d_req_ready, d_rsp_valid, d_rsp_rdata, d_rsp_err,
               mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb
    );
    modport master (
        output if_req_valid, if_req_addr, d_req_valid, d_req_addr, d_req_we,
               d_req_wdata, d_req_wstrb, mem_rdata,
        input  if_req_ready, if_rsp_valid, if_rsp_rdata, if_rsp_err,
               d_req_ready, d_rsp_valid, d_rsp_rdata, d_rsp_err,
               mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/unified_mem_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-request round-robin grant, active only while en is high.
// Ports: clk, reset (async active-low), en, req_if/req_d in, gnt_if/gnt_d out.
// A tie goes to the port that did not win last; last_grant resets to DATA so
// IF wins the first tie.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic req_if,
    input  logic req_d,
    output logic gnt_if,
    output logic gnt_d
);
    port_e last_grant;

    always_comb begin
        gnt_if = en && req_if && (!req_d || last_grant == PORT_DATA);
        gnt_d  = en && req_d && (!req_if || last_grant == PORT_IF);
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset)
            last_grant <= PORT_DATA;
        else if (gnt_if || gnt_d)
            last_grant <= gnt_d ? PORT_DATA : PORT_IF;
endmodule

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one fixed-latency single-port memory between IF and DATA.
// Ports: clk, reset (async active-low), bus (slave modport) carrying the IF
// and DATA request/response channels and the memory interface.
// One transaction in flight: IDLE accepts, ISSUE strobes memory for one cycle,
// WAIT counts MEM_LAT, RESP pulses the granted port. Misaligned requests skip
// straight to RESP with an error and never touch memory.
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    unified_mem_arbiter_if.slave   bus
);
    localparam int CW = $clog2(MAX_MEM_LAT);
    localparam logic [CW-1:0] LAT_M1 = CW'(MEM_LAT - 1);

    arb_state_e    state, state_nx;
    port_e         port_q;
    logic [AW-3:0] addr_q;
    logic          we_q;
    logic [31:0]   wdata_q;
    logic [3:0]    wstrb_q;
    logic [31:0]   rdata_q;
    logic          err_q;
    logic [CW-1:0] cnt_q;
    logic          gnt_if, gnt_d, hs;
    logic [AW-1:0] req_addr;

    rr_arbiter2 u_rr (
        .clk    (clk),
        .reset  (reset),
        .en     (state == IDLE),
        .req_if (bus.if_req_valid),
        .req_d  (bus.d_req_valid),
        .gnt_if (gnt_if),
        .gnt_d  (gnt_d)
    );

    always_comb begin
        hs       = gnt_if || gnt_d;
        req_addr = gnt_d ? bus.d_req_addr : bus.if_req_addr;
        state_nx = state == IDLE  ? (hs ? (|req_addr[1:0] ? RESP : ISSUE) : IDLE) :
                   state == ISSUE ? WAIT :
                   state == WAIT  ? (cnt_q == '0 ? RESP : WAIT) : IDLE;
        bus.if_req_ready = gnt_if;
        bus.d_req_ready  = gnt_d;
        bus.mem_en       = state == ISSUE;
        bus.mem_we       = state == ISSUE && we_q;
        bus.mem_addr     = state == ISSUE ? addr_q : '0;
        bus.mem_wdata    = state == ISSUE ? wdata_q : '0;
        bus.mem_wstrb    = state == ISSUE ? wstrb_q : '0;
        bus.if_rsp_valid = state == RESP && port_q == PORT_IF;
        bus.if_rsp_rdata = bus.if_rsp_valid ? rdata_q : '0;
        bus.if_rsp_err   = bus.if_rsp_valid && err_q;
        bus.d_rsp_valid  = state == RESP && port_q == PORT_DATA;
        bus.d_rsp_rdata  = bus.d_rsp_valid ? rdata_q : '0;
        bus.d_rsp_err    = bus.d_rsp_valid && err_q;
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state   <= IDLE;
            port_q  <= PORT_IF;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state <= state_nx;
            if (hs) begin
                port_q  <= gnt_d ? PORT_DATA : PORT_IF;
                addr_q  <= req_addr[AW-1:2];
                we_q    <= gnt_d && bus.d_req_we;
                wdata_q <= gnt_d ? bus.d_req_wdata : '0;
                wstrb_q <= gnt_d ? bus.d_req_wstrb : '0;
                err_q   <= |req_addr[1:0];
                rdata_q <= '0;
            end
            if (state == ISSUE)
                cnt_q <= LAT_M1;
            else if (state == WAIT && cnt_q != '0)
                cnt_q <= cnt_q - 1'b1;
            // writes acknowledge with zero data
            if (state == WAIT && cnt_q == '0)
                rdata_q <= we_q ? '0 : bus.mem_rdata;
        end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: directed vector bench for unified_mem_arbiter at MEM_LAT 1 and 3.
module tb_unified_mem_arbiter;
    typedef struct {
        bit          sel;
        bit          is_d;
        logic [31:0] addr;
        bit          we;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        bit          err;
    } vec_t;

    typedef struct {
        logic        if_ready, d_ready, if_rv, if_err, d_rv, d_err;
        logic        mem_en, mem_we;
        logic [31:0] if_rd, d_rd, mem_wdata;
        logic [29:0] mem_addr;
        logic [3:0]  mem_wstrb;
    } obs_t;

    logic clk = 0, rst_n = 0;
    always #5 clk = ~clk;

    logic        iv[2], dv[2], dwe[2];
    logic [31:0] ia[2], da[2], dw[2];
    logic [3:0]  ds[2];
    obs_t        obs[2];
    int checks = 0, failures = 0;

    logic        pl_en = 0, pl_sel = 0;
    logic [5:0]  pl_a = 0;
    logic [31:0] pl_d = 0;
    logic [31:0] mem1[64], mem3[64];
    logic [31:0] rd1 = 0, rd3 = 0;

    unified_mem_arbiter_if #(.AW(32)) b1();
    unified_mem_arbiter_if #(.AW(32)) b3();

    unified_mem_arbiter #(.AW(32), .MEM_LAT(1)) u1 (.clk(clk), .reset(rst_n), .bus(b1.slave));
    unified_mem_arbiter #(.AW(32), .MEM_LAT(3)) u3 (.clk(clk), .reset(rst_n), .bus(b3.slave));

    assign b1.if_req_valid = iv[0];
    assign b1.if_req_addr  = ia[0];
    assign b1.d_req_valid  = dv[0];
    assign b1.d_req_addr   = da[0];
    assign b1.d_req_we     = dwe[0];
    assign b1.d_req_wdata  = dw[0];
    assign b1.d_req_wstrb  = ds[0];
    assign b1.mem_rdata    = rd1;
    assign b3.if_req_valid = iv[1];
    assign b3.if_req_addr  = ia[1];
    assign b3.d_req_valid  = dv[1];
    assign b3.d_req_addr   = da[1];
    assign b3.d_req_we     = dwe[1];
    assign b3.d_req_wdata  = dw[1];
    assign b3.d_req_wstrb  = ds[1];
    assign b3.mem_rdata    = rd3;

    always_comb begin
        obs[0] = '{b1.if_req_ready, b1.d_req_ready, b1.if_rsp_valid, b1.if_rsp_err,
                   b1.d_rsp_valid, b1.d_rsp_err, b1.mem_en, b1.mem_we,
                   b1.if_rsp_rdata, b1.d_rsp_rdata, b1.mem_wdata, b1.mem_addr, b1.mem_wstrb};
        obs[1] = '{b3.if_req_ready, b3.d_req_ready, b3.if_rsp_valid, b3.if_rsp_err,
                   b3.d_rsp_valid, b3.d_rsp_err, b3.mem_en, b3.mem_we,
                   b3.if_rsp_rdata, b3.d_rsp_rdata, b3.mem_wdata, b3.mem_addr, b3.mem_wstrb};
    end

    // byte-enable memory models with a registered read port
    always @(posedge clk) begin
        if (pl_en && !pl_sel) mem1[pl_a] <= pl_d;
        if (pl_en && pl_sel)  mem3[pl_a] <= pl_d;
        if (b1.mem_en) begin
            if (b1.mem_we)
                for (int k = 0; k < 4; k++)
                    if (b1.mem_wstrb[k]) mem1[b1.mem_addr[5:0]][8*k +: 8] <= b1.mem_wdata[8*k +: 8];
            rd1 <= mem1[b1.mem_addr[5:0]];
        end
        if (b3.mem_en) begin
            if (b3.mem_we)
                for (int k = 0; k < 4; k++)
                    if (b3.mem_wstrb[k]) mem3[b3.mem_addr[5:0]][8*k +: 8] <= b3.mem_wdata[8*k +: 8];
            rd3 <= mem3[b3.mem_addr[5:0]];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input bit sel, input logic [5:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1; pl_sel = sel; pl_a = a; pl_d = d;
        @(negedge clk);
        pl_en = 0;
    endtask

    task automatic run(input vec_t v);
        int lat, n, en_n;
        bit got;
        obs_t o;
        lat = v.err ? 1 : ((v.sel ? 3 : 1) + 2);
        @(negedge clk);
        if (v.is_d) begin
            dv[v.sel] = 1; da[v.sel] = v.addr; dwe[v.sel] = v.we; dw[v.sel] = v.wdata; ds[v.sel] = v.wstrb;
        end else begin
            iv[v.sel] = 1; ia[v.sel] = v.addr;
        end
        got = 0;
        for (int i = 0; i < 20; i++) begin
            #1 o = obs[v.sel];
            if (v.is_d ? o.d_ready : o.if_ready) begin got = 1; break; end
            @(negedge clk);
        end
        chk("accept", 32'(got), 1);
        @(negedge clk);
        iv[v.sel] = 0; dv[v.sel] = 0;
        n = 1; en_n = 0; got = 0;
        for (int i = 0; i < 12; i++) begin
            #1 o = obs[v.sel];
            if (o.mem_en) begin
                en_n++;
                chk("mem_en_cycle", n, 1);
                chk("mem_addr", 32'(o.mem_addr), {2'b00, v.addr[31:2]});
                chk("mem_we", 32'(o.mem_we), 32'(v.we));
                if (v.we) begin
                    chk("mem_wdata", o.mem_wdata, v.wdata);
                    chk("mem_wstrb", 32'(o.mem_wstrb), 32'(v.wstrb));
                end
            end
            if (v.is_d ? o.d_rv : o.if_rv) begin
                got = 1;
                chk("rsp_latency", n, lat);
                chk("rsp_rdata", v.is_d ? o.d_rd : o.if_rd, v.rdata);
                chk("rsp_err", 32'(v.is_d ? o.d_err : o.if_err), 32'(v.err));
                chk("other_rsp_quiet", 32'(v.is_d ? o.if_rv : o.d_rv), 0);
                break;
            end
            @(negedge clk);
            n++;
        end
        chk("rsp_seen", 32'(got), 1);
        chk("mem_en_count", en_n, v.err ? 0 : 1);
        @(negedge clk);
        #1 o = obs[v.sel];
        chk("rsp_pulse_end", 32'(o.if_rv | o.d_rv), 0);
    endtask

    vec_t vt[10];
    int   g[$];
    int   last_g, n_rsp;
    obs_t o;

    initial begin
        for (int s = 0; s < 2; s++) begin
            iv[s] = 0; dv[s] = 0; dwe[s] = 0; ia[s] = 0; da[s] = 0; dw[s] = 0; ds[s] = 0;
        end
        vt[0] = '{0, 0, 32'h10, 0, 32'h0,         4'h0, 32'hDEADBEEF, 0};
        vt[1] = '{0, 1, 32'h20, 1, 32'hA5A5_0000, 4'hC, 32'h0,        0};
        vt[2] = '{0, 1, 32'h20, 0, 32'h0,         4'h0, 32'hA5A5_3344, 0};
        vt[3] = '{0, 1, 32'h22, 1, 32'h1234_5678, 4'hF, 32'h0,        1};
        vt[4] = '{0, 0, 32'h12, 0, 32'h0,         4'h0, 32'h0,        1};
        vt[5] = '{0, 1, 32'h20, 1, 32'hFFFF_FFFF, 4'h0, 32'h0,        0};
        vt[6] = '{0, 1, 32'h20, 0, 32'h0,         4'h0, 32'hA5A5_3344, 0};
        vt[7] = '{0, 0, 32'h20, 0, 32'h0,         4'h0, 32'hA5A5_3344, 0};
        vt[8] = '{1, 0, 32'h10, 0, 32'h0,         4'h0, 32'hCAFE_F00D, 0};
        vt[9] = '{1, 1, 32'h18, 1, 32'h0000_00EE, 4'h1, 32'h0,        0};

        preload(0, 4, 32'hDEADBEEF);
        preload(0, 8, 32'h1122_3344);
        preload(1, 4, 32'hCAFE_F00D);
        preload(1, 5, 32'h0BAD_F00D);

        #1 o = obs[0];
        chk("rst_mem_en", 32'(o.mem_en), 0);
        chk("rst_rsp_valid", 32'(o.if_rv | o.d_rv), 0);
        chk("rst_ready", 32'(o.if_ready | o.d_ready), 0);
        chk("rst_mem_addr", 32'(o.mem_addr), 0);
        @(negedge clk);
        rst_n = 1;

        foreach (vt[i]) run(vt[i]);

        // continuous dual requests after reset: IF, DATA, IF, DATA
        @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        iv[0] = 1; ia[0] = 32'h10; dv[0] = 1; da[0] = 32'h20; dwe[0] = 0;
        last_g = -1; n_rsp = 0;
        for (int c = 0; c < 17; c++) begin
            #1 o = obs[0];
            if (o.if_ready) g.push_back(0);
            if (o.d_ready) g.push_back(1);
            if (o.if_rv) begin
                n_rsp++;
                chk("alt_if_rsp_port", last_g, 0);
                chk("alt_if_rdata", o.if_rd, 32'hDEADBEEF);
            end
            if (o.d_rv) begin
                n_rsp++;
                chk("alt_d_rsp_port", last_g, 1);
                chk("alt_d_rdata", o.d_rd, 32'hA5A5_3344);
            end
            if (o.if_ready | o.d_ready) last_g = o.d_ready ? 1 : 0;
            @(negedge clk);
        end
        iv[0] = 0; dv[0] = 0;
        chk("alt_grant_count", g.size(), 5);
        for (int i = 0; i < g.size(); i++) chk("alt_grant_order", g[i], i % 2);
        chk("alt_rsp_count", n_rsp, 4);
        repeat (6) @(negedge clk);

        // reset during WAIT on the MEM_LAT=3 instance drops the transaction
        iv[1] = 1; ia[1] = 32'h10;
        begin
            bit got = 0;
            for (int i = 0; i < 20; i++) begin
                #1 o = obs[1];
                if (o.if_ready) begin got = 1; break; end
                @(negedge clk);
            end
            chk("rstw_accept", 32'(got), 1);
        end
        @(negedge clk);
        iv[1] = 0;
        #1 o = obs[1];
        chk("rstw_issue_en", 32'(o.mem_en), 1);
        @(negedge clk);
        #2 rst_n = 0;
        #1 o = obs[1];
        chk("rstw_mem_en", 32'(o.mem_en), 0);
        chk("rstw_rsp_valid", 32'(o.if_rv | o.d_rv), 0);
        @(negedge clk);
        rst_n = 1;
        n_rsp = 0;
        for (int c = 0; c < 10; c++) begin
            #1 o = obs[1];
            if (o.if_rv | o.d_rv | o.mem_en) n_rsp++;
            @(negedge clk);
        end
        chk("rstw_dropped_quiet", n_rsp, 0);
        run('{1, 0, 32'h14, 0, 32'h0, 4'h0, 32'h0BAD_F00D, 0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
